// File: rtl/shortest_path_engine.sv
// Dijkstra single-source shortest-path engine: LANES edge weights per memory word, LANES relaxations per cycle.
// Optional statistics counters are enabled by defining SPE_STATS_EN.
module shortest_path_engine #(
    parameter int MAX_NODES   = 16,
    parameter int LANES       = 4,
    parameter int INDEX_WIDTH = 4,
    parameter int VALUE_WIDTH = 16,
    parameter int MADDR_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         full_sweep,
    input  logic [INDEX_WIDTH-1:0]       source,
    input  logic [INDEX_WIDTH-1:0]       destination,
    input  logic [INDEX_WIDTH:0]         number_of_nodes,
    input  logic [MADDR_WIDTH-1:0]       base_address,
    output logic                         mem_read_enable,
    output logic [MADDR_WIDTH-1:0]       mem_addr,
    input  logic                         mem_read_ready,
    input  logic [LANES*VALUE_WIDTH-1:0] mem_read_data,
    output logic                         busy,
    output logic                         done,
    output logic                         found,
    output logic                         error,
    input  logic [INDEX_WIDTH-1:0]       query_index,
    output logic [VALUE_WIDTH-1:0]       query_distance,
    output logic [INDEX_WIDTH-1:0]       query_prev
`ifdef SPE_STATS_EN
    ,
    output logic [31:0]                  stat_cycles,
    output logic [31:0]                  stat_reads,
    output logic [15:0]                  stat_relax
`endif
);

    localparam int WPR = MAX_NODES / LANES;
    localparam int WW  = INDEX_WIDTH + 1;
    localparam logic [VALUE_WIDTH-1:0] INF  = '1;
    localparam logic [INDEX_WIDTH-1:0] NONE = '1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_SELECT = 3'd2;
    localparam logic [2:0] S_FETCH  = 3'd3;
    localparam logic [2:0] S_RELAX  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]                   state_reg;
    logic                         busy_reg;
    logic                         done_reg;
    logic                         found_reg;
    logic                         error_reg;
    logic                         rd_en_reg;
    logic [MADDR_WIDTH-1:0]       addr_reg;
    logic                         full_sweep_reg;
    logic [INDEX_WIDTH-1:0]       src_reg;
    logic [INDEX_WIDTH-1:0]       dst_reg;
    logic [INDEX_WIDTH-1:0]       cur_reg;
    logic [INDEX_WIDTH:0]         num_reg;
    logic [MADDR_WIDTH-1:0]       base_reg;
    logic [WW-1:0]                word_reg;
    logic [LANES*VALUE_WIDTH-1:0] data_reg;
    logic [VALUE_WIDTH-1:0]       dist_reg [MAX_NODES];
    logic [INDEX_WIDTH-1:0]       prev_reg [MAX_NODES];
    logic [MAX_NODES-1:0]         visited_reg;

    logic                         start_accept;
    logic                         cfg_bad;
    logic                         last_word;
    logic                         sel_valid;
    logic [INDEX_WIDTH-1:0]       sel_idx;
    logic [VALUE_WIDTH-1:0]       sel_min;
    logic [VALUE_WIDTH-1:0]       dist_cur;
    logic [VALUE_WIDTH-1:0]       lane_weight [LANES];
    logic [VALUE_WIDTH-1:0]       lane_alt    [LANES];
    logic [MAX_NODES-1:0]         relax_en;

    assign start_accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign cfg_bad   = (num_reg == '0) || (32'(num_reg) > MAX_NODES) || ({1'b0, src_reg} >= num_reg);
    assign last_word = ((32'(word_reg) + 32'd1) * LANES) >= 32'(num_reg);
    assign dist_cur  = dist_reg[cur_reg];

    // Strict less-than keeps the lowest index on ties and never selects an INF node.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_min   = INF;
        for (int i = 0; i < MAX_NODES; i++) begin
            if (i < int'(num_reg) && !visited_reg[i] && dist_reg[i] < sel_min) begin
                sel_valid = 1'b1;
                sel_idx   = INDEX_WIDTH'(i);
                sel_min   = dist_reg[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [VALUE_WIDTH:0] sum;
            assign lane_weight[gi] = data_reg[gi*VALUE_WIDTH +: VALUE_WIDTH];
            assign sum             = {1'b0, dist_cur} + {1'b0, lane_weight[gi]};
            assign lane_alt[gi]    = sum[VALUE_WIDTH] ? INF : sum[VALUE_WIDTH-1:0];
        end
        // Node gi lives in word gi/LANES, lane gi%LANES of its row.
        for (gi = 0; gi < MAX_NODES; gi++) begin : g_node
            assign relax_en[gi] = (state_reg == S_RELAX) &&
                                  (word_reg == WW'(gi / LANES)) &&
                                  (WW'(gi) < num_reg) &&
                                  !visited_reg[gi] &&
                                  (lane_weight[gi % LANES] != INF) &&
                                  (lane_alt[gi % LANES] < dist_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            found_reg      <= 1'b0;
            error_reg      <= 1'b0;
            rd_en_reg      <= 1'b0;
            addr_reg       <= '0;
            full_sweep_reg <= 1'b0;
            src_reg        <= '0;
            dst_reg        <= '0;
            cur_reg        <= '0;
            num_reg        <= '0;
            base_reg       <= '0;
            word_reg       <= '0;
            data_reg       <= '0;
            visited_reg    <= '0;
            for (int i = 0; i < MAX_NODES; i++) begin
                dist_reg[i] <= INF;
                prev_reg[i] <= NONE;
            end
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        full_sweep_reg <= full_sweep;
                        src_reg        <= source;
                        dst_reg        <= destination;
                        num_reg        <= number_of_nodes;
                        base_reg       <= base_address;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                        state_reg      <= S_INIT;
                    end
                end
                S_INIT: begin
                    found_reg <= 1'b0;
                    if (cfg_bad) begin
                        error_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        error_reg   <= 1'b0;
                        visited_reg <= '0;
                        for (int i = 0; i < MAX_NODES; i++) begin
                            dist_reg[i] <= INF;
                            prev_reg[i] <= NONE;
                        end
                        dist_reg[src_reg] <= '0;
                        state_reg         <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (!sel_valid) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        found_reg <= full_sweep_reg && (dist_reg[dst_reg] != INF);
                        state_reg <= S_DONE;
                    end else begin
                        cur_reg              <= sel_idx;
                        visited_reg[sel_idx] <= 1'b1;
                        word_reg             <= '0;
                        if (!full_sweep_reg && sel_idx == dst_reg) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            found_reg <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            addr_reg  <= base_reg + MADDR_WIDTH'(sel_idx) * MADDR_WIDTH'(WPR);
                            rd_en_reg <= 1'b1;
                            state_reg <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (mem_read_ready) begin
                        data_reg  <= mem_read_data;
                        rd_en_reg <= 1'b0;
                        state_reg <= S_RELAX;
                    end
                end
                S_RELAX: begin
                    for (int i = 0; i < MAX_NODES; i++) begin
                        if (relax_en[i]) begin
                            dist_reg[i] <= lane_alt[i % LANES];
                            prev_reg[i] <= cur_reg;
                        end
                    end
                    word_reg <= word_reg + 1'b1;
                    if (last_word) begin
                        state_reg <= S_SELECT;
                    end else begin
                        addr_reg  <= addr_reg + 1'b1;
                        rd_en_reg <= 1'b1;
                        state_reg <= S_FETCH;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef SPE_STATS_EN
    logic [31:0] cycles_reg;
    logic [31:0] reads_reg;
    logic [15:0] relax_reg;
    logic [15:0] relax_count;

    always_comb begin
        relax_count = '0;
        for (int i = 0; i < MAX_NODES; i++) begin
            relax_count = relax_count + 16'(relax_en[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycles_reg <= '0;
            reads_reg  <= '0;
            relax_reg  <= '0;
        end else if (start_accept) begin
            cycles_reg <= '0;
            reads_reg  <= '0;
            relax_reg  <= '0;
        end else begin
            if (busy_reg) cycles_reg <= cycles_reg + 1'b1;
            if (state_reg == S_FETCH && mem_read_ready) reads_reg <= reads_reg + 1'b1;
            relax_reg <= relax_reg + relax_count;
        end
    end

    assign stat_cycles = cycles_reg;
    assign stat_reads  = reads_reg;
    assign stat_relax  = relax_reg;
`else
    logic unused_accept;
    assign unused_accept = start_accept;
`endif

    assign busy            = busy_reg;
    assign done            = done_reg;
    assign found           = found_reg;
    assign error           = error_reg;
    assign mem_read_enable = rd_en_reg;
    assign mem_addr        = addr_reg;
    assign query_distance  = dist_reg[query_index];
    assign query_prev      = prev_reg[query_index];

endmodule

// File: tb/tb_shortest_path_engine.sv
// Directed self-checking bench for shortest_path_engine with a latency-configurable memory responder.
module tb_shortest_path_engine;

    localparam logic [15:0] INF  = 16'hFFFF;
    localparam logic [3:0]  NONE = 4'hF;
    localparam int          BASE = 256;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        full_sweep;
    logic [3:0]  source;
    logic [3:0]  destination;
    logic [4:0]  number_of_nodes;
    logic [15:0] base_address;
    logic        mem_read_enable;
    logic [15:0] mem_addr;
    logic        mem_read_ready;
    logic [63:0] mem_read_data;
    logic        busy;
    logic        done;
    logic        found;
    logic        error;
    logic [3:0]  query_index;
    logic [15:0] query_distance;
    logic [3:0]  query_prev;
`ifdef SPE_STATS_EN
    logic [31:0] stat_cycles;
    logic [31:0] stat_reads;
    logic [15:0] stat_relax;
`endif

    logic [63:0] mem [0:1023];
    int  pass_cnt = 0;
    int  fail_cnt = 0;
    int  total_cnt = 0;
    int  read_count = 0;
    int  addr_violations = 0;
    bit  rand_lat = 1'b0;

    always #5 clock = ~clock;

    shortest_path_engine dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .full_sweep      (full_sweep),
        .source          (source),
        .destination     (destination),
        .number_of_nodes (number_of_nodes),
        .base_address    (base_address),
        .mem_read_enable (mem_read_enable),
        .mem_addr        (mem_addr),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .busy            (busy),
        .done            (done),
        .found           (found),
        .error           (error),
        .query_index     (query_index),
        .query_distance  (query_distance),
        .query_prev      (query_prev)
`ifdef SPE_STATS_EN
        ,
        .stat_cycles     (stat_cycles),
        .stat_reads      (stat_reads),
        .stat_relax      (stat_relax)
`endif
    );

    // Memory responder: answers requests after 0 or random 0..7 cycles; in random mode also
    // raises stray ready pulses with bogus data while no request is pending.
    initial begin
        int          wait_cnt;
        bit          prev_en;
        logic [15:0] prev_addr;
        wait_cnt       = 0;
        prev_en        = 1'b0;
        prev_addr      = '0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        forever begin
            @(negedge clock);
            mem_read_ready = 1'b0;
            if (reset_n !== 1'b1) begin
                prev_en = 1'b0;
            end else if (mem_read_enable) begin
                if (prev_en && mem_addr !== prev_addr) addr_violations++;
                if (wait_cnt == 0) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = mem[mem_addr[9:0]];
                    read_count++;
                    wait_cnt = rand_lat ? int'($urandom_range(0, 7)) : 0;
                    prev_en  = 1'b0;
                end else begin
                    wait_cnt--;
                    prev_en   = 1'b1;
                    prev_addr = mem_addr;
                end
            end else begin
                prev_en = 1'b0;
                if (rand_lat && $urandom_range(0, 2) == 0) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = {4{16'h0001}};
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '1;
    endtask

    task automatic set_edge(input int u, input int v, input logic [15:0] w);
        int a;
        a = BASE + u * 4 + v / 4;
        mem[a][(v % 4) * 16 +: 16] = w;
    endtask

    task automatic run(input bit fs, input int src, input int dst, input int num);
        @(negedge clock);
        full_sweep      = fs;
        source          = src[3:0];
        destination     = dst[3:0];
        number_of_nodes = num[4:0];
        base_address    = 16'(BASE);
        start           = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 4000) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic qd(input string tag, input int idx, input logic [15:0] exp);
        query_index = idx[3:0];
        #1;
        check(tag, 32'(query_distance), 32'(exp));
    endtask

    task automatic qp(input string tag, input int idx, input logic [3:0] exp);
        query_index = idx[3:0];
        #1;
        check(tag, 32'(query_prev), 32'(exp));
    endtask

    initial begin
        int r0;
        int v0;
        int n;
        reset_n         = 1'b0;
        start           = 1'b0;
        full_sweep      = 1'b0;
        source          = '0;
        destination     = '0;
        number_of_nodes = '0;
        base_address    = '0;
        query_index     = '0;
        clear_mem();

        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_rden", 32'(mem_read_enable), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        qd("rst_dist0", 0, INF);
        qp("rst_prev0", 0, NONE);
        @(negedge clock);
        reset_n = 1'b1;

        // 4-node chain, early exit at node 3
        set_edge(0, 1, 16'd3);
        set_edge(1, 2, 16'd4);
        set_edge(2, 3, 16'd5);
        run(1'b0, 0, 3, 4);
        wait_done("chain_done");
        check("chain_found", 32'(found), 32'd1);
        check("chain_error", 32'(error), 32'd0);
        check("chain_busy", 32'(busy), 32'd0);
        qd("chain_dist3", 3, 16'd12);
        qd("chain_dist0", 0, 16'd0);
        qp("chain_prev3", 3, 4'd2);
        qp("chain_prev2", 2, 4'd1);
        qp("chain_prev1", 1, 4'd0);
        qp("chain_prev0", 0, NONE);

        // Direct 0->3 edge of 20 is later improved to 12 via the chain
        set_edge(0, 3, 16'd20);
        r0 = read_count;
        run(1'b1, 0, 3, 4);
        wait_done("sweep_done");
        check("sweep_found", 32'(found), 32'd1);
        qd("sweep_dist0", 0, 16'd0);
        qd("sweep_dist1", 1, 16'd3);
        qd("sweep_dist2", 2, 16'd7);
        qd("sweep_dist3", 3, 16'd12);
        qp("sweep_prev3", 3, 4'd2);
        check("sweep_reads", 32'(read_count - r0), 32'd4);

        // Same run under random latency and stray ready pulses
        rand_lat = 1'b1;
        r0 = read_count;
        v0 = addr_violations;
        run(1'b1, 0, 3, 4);
        wait_done("lat_done");
        rand_lat = 1'b0;
        check("lat_found", 32'(found), 32'd1);
        qd("lat_dist1", 1, 16'd3);
        qd("lat_dist2", 2, 16'd7);
        qd("lat_dist3", 3, 16'd12);
        qp("lat_prev3", 3, 4'd2);
        qp("lat_prev2", 2, 4'd1);
        check("lat_reads", 32'(read_count - r0), 32'd4);
        check("lat_addr_stable", 32'(addr_violations - v0), 32'd0);

        // Illegal configurations: no read issued, done within 2 cycles
        r0 = read_count;
        run(1'b0, 9, 0, 8);
        @(negedge clock);
        check("err_src_error", 32'(error), 32'd1);
        check("err_src_done", 32'(done), 32'd1);
        check("err_src_busy", 32'(busy), 32'd0);
        run(1'b0, 0, 0, 17);
        @(negedge clock);
        check("err_n17_error", 32'(error), 32'd1);
        run(1'b0, 0, 0, 0);
        @(negedge clock);
        check("err_n0_error", 32'(error), 32'd1);
        check("err_no_reads", 32'(read_count - r0), 32'd0);

        // 6 nodes, node 5 isolated; edge to node 6 lies beyond the active count
        clear_mem();
        set_edge(0, 1, 16'd3);
        set_edge(1, 2, 16'd4);
        set_edge(2, 3, 16'd5);
        set_edge(3, 4, 16'd1);
        set_edge(0, 6, 16'd1);
        run(1'b0, 0, 5, 6);
        wait_done("iso_done");
        check("iso_error", 32'(error), 32'd0);
        check("iso_found", 32'(found), 32'd0);
        qd("iso_dist5", 5, INF);
        qp("iso_prev5", 5, NONE);
        qd("iso_dist4", 4, 16'd13);
        qp("iso_prev4", 4, 4'd3);
        qd("iso_dist6", 6, INF);

        // 16-node graph: unit chain with a zero-weight 3->4 hop, plus 0->v weight 100 shortcuts
        clear_mem();
        for (int v = 2; v < 16; v++) set_edge(0, v, 16'd100);
        for (int u = 0; u < 15; u++) set_edge(u, u + 1, (u == 3) ? 16'd0 : 16'd1);
        r0 = read_count;
        run(1'b1, 0, 15, 16);
        n = 0;
        while ((read_count - r0) < 10 && n < 2000) begin
            @(negedge clock);
            #2;
            n++;
        end
        check("abort_reached", 32'(read_count - r0 >= 10), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rden", 32'(mem_read_enable), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        qd("abort_dist1", 1, INF);
        @(negedge clock);
        reset_n = 1'b1;

        r0 = read_count;
        run(1'b1, 0, 15, 16);
        wait_done("big_done");
        check("big_found", 32'(found), 32'd1);
        qd("big_dist2", 2, 16'd2);
        qd("big_dist3", 3, 16'd3);
        qd("big_dist4", 4, 16'd3);
        qd("big_dist15", 15, 16'd14);
        qp("big_prev4", 4, 4'd3);
        qp("big_prev15", 15, 4'd14);
        qp("big_prev0", 0, NONE);
        check("big_reads", 32'(read_count - r0), 32'd64);
`ifdef SPE_STATS_EN
        check("stat_reads", stat_reads, 32'd64);
        check("stat_relax", 32'(stat_relax), 32'd29);
        check("stat_cycles_nz", 32'(stat_cycles != 0), 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
